// File: rtl/bist_session_scheduler_pkg.sv
// Shared definitions for the multi-session BIST scheduler: 3-bit state
// encoding and the default MISR signature width.
package bist_session_scheduler_pkg;

    localparam int DEFAULT_SIG_W = 21;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_COMPARE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/bist_cycle_counter.sv
// Shift/pattern counter pair for the BIST scheduler; terminal counts flag the
// last shift cycle of a chain load and the capture that completes a session.
module bist_cycle_counter #(
    parameter int CHAIN_LEN  = 16,
    parameter int N_PATTERNS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift_en,
    input  logic pat_en,
    output logic shift_tc,
    output logic pat_tc
);

    localparam int SW = $clog2(CHAIN_LEN + 1);
    localparam int PW = $clog2(N_PATTERNS + 1);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST   = PW'(N_PATTERNS - 1);

    logic [SW-1:0] shift_cnt;
    logic [PW-1:0] pat_cnt;

    // The shift count reloads on its terminal count so SHIFT and FLUSH each
    // start from zero without the FSM having to pulse clr between them.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shift_cnt <= '0;
            pat_cnt   <= '0;
        end else begin
            if (shift_en)
                shift_cnt <= shift_tc ? '0 : shift_cnt + SW'(1);
            if (pat_en)
                pat_cnt <= pat_cnt + PW'(1);
        end
    end

    assign shift_tc = (shift_cnt == SHIFT_LAST);
    assign pat_tc   = (pat_cnt == PAT_LAST);

endmodule

// File: rtl/bist_session_scheduler.sv
// Multi-session BIST sequencer: reseed, shift/capture, flush, signature compare.
// Optional macro BIST_SCHED_EARLY_STOP_EN ends the run at the first miscompare.
module bist_session_scheduler
    import bist_session_scheduler_pkg::*;
#(
    parameter int CHAIN_LEN  = 16,
    parameter int N_PATTERNS = 64,
    parameter int N_SESSIONS = 4,
    parameter int SIG_W      = DEFAULT_SIG_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SIG_W-1:0]      sig,
    input  logic [SIG_W-1:0]      golden,
    output logic                  scan_en,
    output logic                  seed_ld,
    output logic                  misr_clr,
    output logic [((N_SESSIONS > 1) ? $clog2(N_SESSIONS) : 1)-1:0] session_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_SESSIONS-1:0] fail_map
);

    localparam int IW = (N_SESSIONS > 1) ? $clog2(N_SESSIONS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_SESSIONS - 1);

    state_t                state;
    logic                  shift_en;
    logic                  pat_en;
    logic                  cnt_clr;
    logic                  shift_tc;
    logic                  pat_tc;
    logic                  miscompare;
    logic                  stop;
    logic [N_SESSIONS-1:0] fail_next;

    assign shift_en = (state == ST_SHIFT) || (state == ST_FLUSH);
    assign pat_en   = (state == ST_CAPTURE);
    assign cnt_clr  = (state == ST_IDLE) || (state == ST_SEED);

    bist_cycle_counter #(
        .CHAIN_LEN  (CHAIN_LEN),
        .N_PATTERNS (N_PATTERNS)
    ) u_cnt (
        .clk      (CLK),
        .rst      (RST),
        .clr      (cnt_clr),
        .shift_en (shift_en),
        .pat_en   (pat_en),
        .shift_tc (shift_tc),
        .pat_tc   (pat_tc)
    );

    // fail_next folds in this cycle's compare so pass can be decided on the
    // same edge that enters DONE.
    always_comb begin
        miscompare = (sig != golden);
        fail_next  = fail_map;
        if (miscompare)
            fail_next[session_idx] = 1'b1;
`ifdef BIST_SCHED_EARLY_STOP_EN
        stop = (session_idx == LAST_IDX) || miscompare;
`else
        stop = (session_idx == LAST_IDX);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            scan_en     <= 1'b0;
            seed_ld     <= 1'b0;
            misr_clr    <= 1'b0;
            session_idx <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_map    <= '0;
        end else begin
            seed_ld  <= 1'b0;
            misr_clr <= 1'b0;
            done     <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state   <= ST_IDLE;
                scan_en <= 1'b0;
                busy    <= 1'b0;
                pass    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state       <= ST_SEED;
                            seed_ld     <= 1'b1;
                            misr_clr    <= 1'b1;
                            scan_en     <= 1'b0;
                            busy        <= 1'b1;
                            pass        <= 1'b0;
                            fail_map    <= '0;
                            session_idx <= '0;
                        end
                    end
                    ST_SEED: begin
                        state   <= ST_SHIFT;
                        scan_en <= 1'b1;
                    end
                    ST_SHIFT: begin
                        if (shift_tc) begin
                            state   <= ST_CAPTURE;
                            scan_en <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        state   <= pat_tc ? ST_FLUSH : ST_SHIFT;
                        scan_en <= 1'b1;
                    end
                    ST_FLUSH: begin
                        if (shift_tc) begin
                            state   <= ST_COMPARE;
                            scan_en <= 1'b0;
                        end
                    end
                    ST_COMPARE: begin
                        fail_map <= fail_next;
                        if (stop) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_next == '0);
                        end else begin
                            state       <= ST_SEED;
                            seed_ld     <= 1'b1;
                            misr_clr    <= 1'b1;
                            session_idx <= session_idx + IW'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        scan_en <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bist_session_scheduler.sv
// Scoreboard bench for bist_session_scheduler (CHAIN_LEN=4, N_PATTERNS=2,
// N_SESSIONS=2, so one session is 16 cycles).
module tb_bist_session_scheduler;

    localparam int CL = 4;
    localparam int NP = 2;
    localparam int NS = 2;
    localparam int SW = 21;
    localparam int S  = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic          abort;
    logic [SW-1:0] sig;
    logic [SW-1:0] golden;
    logic          scan_en;
    logic          seed_ld;
    logic          misr_clr;
    logic [0:0]    session_idx;
    logic          busy;
    logic          done;
    logic          pass;
    logic [NS-1:0] fail_map;

    logic [1:0]    bad = 2'b00;
    logic          finish_req = 1'b0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Golden differs from the signature only for sessions marked bad.
    always_comb golden = bad[session_idx] ? (sig ^ 21'h00100) : sig;

    bist_session_scheduler #(
        .CHAIN_LEN  (CL),
        .N_PATTERNS (NP),
        .N_SESSIONS (NS),
        .SIG_W      (SW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .abort       (abort),
        .sig         (sig),
        .golden      (golden),
        .scan_en     (scan_en),
        .seed_ld     (seed_ld),
        .misr_clr    (misr_clr),
        .session_idx (session_idx),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_map    (fail_map)
    );

    typedef struct {
        int         cyc;
        logic [8:0] val;
        string      name;
    } snap_t;

    typedef struct {
        int         cyc;
        logic       pass;
        logic [1:0] fm;
    } done_t;

    snap_t snap_q[$];
    int    seed_q[$];
    done_t done_q[$];

    logic [8:0] mon_act;
    int         mon_e;
    done_t      mon_d;

    assign mon_act = {scan_en, seed_ld, misr_clr, busy, done, pass, fail_map, session_idx};

    task automatic push_snap(input int c, input logic [8:0] v, input string name);
        snap_t e;
        e.cyc  = c;
        e.val  = v;
        e.name = name;
        snap_q.push_back(e);
    endtask

    // Expected cycle-by-cycle picture of a run started at cycle t, up to offset kmax.
    task automatic push_run(input int t, input logic [1:0] b, input int kmax, input string tag);
        int nrun, dk, s, w;
        logic sc, sd, bz, dn, ps, ix;
        logic [1:0] f, ffin;
        done_t d;
        nrun = NS;
`ifdef BIST_SCHED_EARLY_STOP_EN
        if (b[0]) nrun = 1;
`endif
        dk   = S * nrun + 1;
        ffin = (nrun == 1) ? (b & 2'b01) : b;
        for (int k = 1; k <= dk + 1 && k <= kmax; k++) begin
            if (k < dk) begin
                s  = (k - 1) / S;
                w  = (k - 1) % S;
                sc = (w >= 1 && w <= 4) || (w >= 6 && w <= 9) || (w >= 11 && w <= 14);
                sd = (w == 0);
                bz = 1'b1;
                dn = 1'b0;
                ps = 1'b0;
                ix = s[0];
                f  = 2'b00;
                for (int i = 0; i < NS; i++)
                    if (k >= S * (i + 1) + 1) f[i] = b[i];
            end else begin
                sc = 1'b0;
                sd = 1'b0;
                bz = 1'b0;
                dn = (k == dk);
                f  = ffin;
                ps = (ffin == 2'b00);
                ix = (nrun == 2);
            end
            push_snap(t + k, {sc, sd, sd, bz, dn, ps, f, ix}, $sformatf("%s k=%0d", tag, k));
        end
        for (int i = 0; i < nrun; i++)
            if (S * i + 1 <= kmax) seed_q.push_back(t + S * i + 1);
        if (dk <= kmax) begin
            d.cyc  = t + dk;
            d.pass = (ffin == 2'b00);
            d.fm   = ffin;
            done_q.push_back(d);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge CLK) begin
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            n_checks++;
            if (snap_q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: snapshot for cycle %0d not checked, now cycle %0d",
                         snap_q[0].name, snap_q[0].cyc, cyc);
            end else if (mon_act !== snap_q[0].val) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %b want %b (scan,seed,clr,busy,done,pass,fmap,idx)",
                         snap_q[0].name, cyc, mon_act, snap_q[0].val);
            end
            void'(snap_q.pop_front());
        end
        if (seed_ld === 1'b1) begin
            n_checks++;
            if (seed_q.size() == 0) begin
                n_fail++;
                $display("FAIL seed_ld: unexpected pulse at cycle %0d", cyc);
            end else begin
                mon_e = seed_q.pop_front();
                if (mon_e != cyc) begin
                    n_fail++;
                    $display("FAIL seed_ld: pulse at cycle %0d, required %0d", cyc, mon_e);
                end
            end
        end
        if (done === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done: unexpected pulse at cycle %0d", cyc);
            end else begin
                mon_d = done_q.pop_front();
                if (mon_d.cyc != cyc || pass !== mon_d.pass || fail_map !== mon_d.fm) begin
                    n_fail++;
                    $display("FAIL done: cyc %0d pass %b fmap %b, required cyc %0d pass %b fmap %b",
                             cyc, pass, fail_map, mon_d.cyc, mon_d.pass, mon_d.fm);
                end
            end
        end
        if (finish_req) begin
            n_checks++;
            if (snap_q.size() != 0 || seed_q.size() != 0 || done_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: leftover snapshots %0d seeds %0d dones %0d, required 0 0 0",
                         snap_q.size(), seed_q.size(), done_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic run_normal(input logic [1:0] b, input string tag);
        int t;
        @(negedge CLK);
        bad = b;
        t   = cyc;
        push_run(t, b, 99, tag);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (40) @(negedge CLK);
    endtask

    initial begin
        int t;
        RST   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        sig   = 21'h0A5A5;
        repeat (2) @(negedge CLK);
        push_snap(cyc + 1, 9'b0, "reset");
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        run_normal(2'b00, "allpass");
        run_normal(2'b10, "s1fail");

        // Reset in IDLE clears the retained result.
        RST = 1'b1;
        push_snap(cyc + 1, 9'b0, "idle_reset");
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        // Abort during SHIFT of session 0.
        bad = 2'b00;
        t   = cyc;
        push_run(t, 2'b00, 7, "abort");
        push_snap(t + 8, 9'b0, "abort_idle");
        push_snap(t + 12, 9'b0, "abort_stay");
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (6) @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        repeat (40) @(negedge CLK);
        run_normal(2'b00, "restart");

        // Reset during FLUSH of session 1.
        bad = 2'b10;
        t   = cyc;
        push_run(t, 2'b10, 29, "rstflush");
        push_snap(t + 30, 9'b0, "rstflush_zero");
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (28) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // start held high through the whole run, dropped after DONE.
        bad = 2'b00;
        t   = cyc;
        push_run(t, 2'b00, 99, "held");
        start = 1'b1;
        repeat (34) @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);

        // start and abort together in IDLE: nothing changes.
        t = cyc;
        push_snap(t + 1, 9'b000001001, "startabort1");
        push_snap(t + 2, 9'b000001001, "startabort2");
        start = 1'b1;
        abort = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        abort = 1'b0;
        repeat (5) @(negedge CLK);

        run_normal(2'b01, "s0fail");

        finish_req = 1'b1;
        repeat (5) @(negedge CLK);
        $display("FAIL finish: monitor did not close the run");
        $fatal(1);
    end

endmodule

// File: doc/bist_session_scheduler.md
# bist_session_scheduler

Multi-session BIST sequencer for the scan-based self-test datapath (pattern LFSR, scan-wrapped circuit, output MISR). It runs `N_SESSIONS` test sessions back to back. Each session:
- reseeds the LFSR and clears the MISR;
- alternates scan-shift and capture cycles for `N_PATTERNS` patterns, then flushes the chain;
- compares the MISR signature against a per-session golden value.

It sits beside the existing BIST controller in the top level, drives the scan-enable / input mux select, and reports per-session and overall pass/fail.

## Interface
- `CHAIN_LEN`, 16: scan chain length in flops (≥1).
- `N_PATTERNS`, 64: capture patterns per session (≥1).
- `N_SESSIONS`, 4: number of sessions (1..16).
- `SIG_W`, 21: MISR signature width.

- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: terminate the run.
- `sig` in `SIG_W`: current MISR signature.
- `golden` in `SIG_W`: expected signature for `session_idx`, looked up externally.
- `scan_en` out 1: scan shift enable; also the datapath mux select (1 = LFSR patterns).
- `seed_ld` out 1: LFSR seed load pulse.
- `misr_clr` out 1: MISR clear pulse.
- `session_idx` out `clog2(N_SESSIONS)` (min 1): session currently running.
- `busy` out 1: high from SEED of session 0 through the last COMPARE.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: overall result, valid from `done` until the next `start`.
- `fail_map` out `N_SESSIONS`: bit i set when session i miscompared.

## Operation
- **States:** IDLE, SEED, SHIFT, CAPTURE, FLUSH, COMPARE, DONE.
- **IDLE:**
  - All strobes are 0.
  - `start`=1 clears `fail_map` and `pass`, sets `session_idx`=0, goes to SEED.
- **SEED** (1 cycle):
  - `seed_ld`=1, `misr_clr`=1, `scan_en`=0.
  - Clears the shift and pattern counters, then goes to SHIFT.
- **SHIFT:**
  - `scan_en`=1 for exactly `CHAIN_LEN` cycles, then goes to CAPTURE.
- **CAPTURE** (1 cycle):
  - `scan_en`=0 and the pattern counter increments.
  - If the counter reaches `N_PATTERNS`, go to FLUSH; otherwise go to SHIFT.
- **FLUSH:**
  - `scan_en`=1 for `CHAIN_LEN` cycles to unload the final response, then goes to COMPARE.
- **COMPARE** (1 cycle):
  - If `sig` != `golden`, set `fail_map[session_idx]`.
  - If this is the last session, go to DONE; otherwise increment `session_idx` and go to SEED.
- **DONE** (1 cycle):
  - `done`=1, `pass` = (`fail_map` == 0) including this cycle's update, then go to IDLE.
- **Session length:** S = 1 + `N_PATTERNS`·(`CHAIN_LEN`+1) + `CHAIN_LEN` + 1 cycles.
- **Counter widths:**
  - Shift counter: `clog2(CHAIN_LEN+1)` bits.
  - Pattern counter: `clog2(N_PATTERNS+1)` bits.
  - No wrap-around inside a session.
- **Boundary conditions:**
  - `start` while not IDLE is ignored.
  - `abort` in any non-IDLE state: next state is IDLE, all strobes go to 0, `pass`=0, `fail_map` is kept, `done` is not pulsed.
  - `abort` and `start` together in IDLE: abort wins and no run begins.
  - `RST` (any state): state=IDLE, every output 0, counters 0.
  - `session_idx` holds its last value in IDLE.

## Timing
- **Reset values:** `scan_en`, `seed_ld`, `misr_clr`, `busy`, `done`, `pass` are 0; `fail_map` = 0; `session_idx` = 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- `start` sampled high at edge t gives SEED (with `seed_ld`) during cycle t+1.
- `done` is high in cycle t+1+`N_SESSIONS`·S.
- `sig` and `golden` are sampled at the COMPARE edge. The MISR must already contain the last FLUSH cycle's data (MISR updates on the same edges as the chain).

## Configuration
- `BIST_SCHED_EARLY_STOP_EN`
  - **Defined:** a miscompare in COMPARE goes straight to DONE. Remaining sessions are skipped, their `fail_map` bits stay 0, and `pass`=0.
  - **Undefined:** all `N_SESSIONS` run regardless of failures.

## Structure
- **Shared BIST package/include:** state encoding constants (3-bit) and the default `SIG_W`.
- **One sub-module, `bist_cycle_counter`:** the shift/pattern counter pair. It has load/enable inputs and terminal-count outputs `shift_tc` and `pat_tc`. The FSM stays in the top module.

## Test plan
Test parameters: `CHAIN_LEN`=4, `N_PATTERNS`=2, `N_SESSIONS`=2, so S=16.
- **All sessions pass:** `golden`=`sig`=21'h0A5A5, start at t.
  - `seed_ld` pulses at t+1 and t+17.
  - `done` at t+33, `pass`=1, `fail_map`=2'b00.
- **Second session fails:** `golden` differs only while `session_idx`=1.
  - `fail_map`=2'b10, `pass`=0, `done` at t+33.
- **Scan waveform:** per session, `scan_en` reads 0,1111,0,1111,0,1111,0. `busy` is high t+1..t+32.
- **Abort:** abort pulse at t+7 (SHIFT).
  - Cycle t+8 is IDLE, `scan_en`=0, no `done`, `pass`=0.
  - A new `start` runs normally.
- **Reset and start collisions:**
  - `RST` mid-FLUSH puts all outputs at 0 the next cycle.
  - `start` held high through a whole run does not restart it before DONE.
  - `start` and `abort` together in IDLE: no run begins.
- **Early stop, `BIST_SCHED_EARLY_STOP_EN` defined:** session 0 fails.
  - `done` at t+17, `fail_map`=2'b01, and `seed_ld` is never pulsed a second time.
